bwn_coef_fetch_ctrl: RTL



---
 rtl/bwn_pkg.sv | 25 ++
 rtl/bwn_skid_fifo2.sv | 67 ++++++
 rtl/bwn_coef_fetch_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bwn_pkg.sv
// bwn_pkg
// Shared constants and types for the binary-weight coefficient fetch path.
// Contents:
//   BWN_COEF_W / BWN_ROM_DEPTH / BWN_ADDR_W / BWN_LEN_W : default geometry
//   bwn_state_e  : fetch controller FSM states
//   bwn_entry_t  : one output FIFO entry {coef, last}
package bwn_pkg;

    localparam int BWN_COEF_W    = 80;
    localparam int BWN_ROM_DEPTH = 120;
    localparam int BWN_ADDR_W    = 12;
    localparam int BWN_LEN_W     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } bwn_state_e;

    typedef struct packed {
        logic [BWN_COEF_W-1:0] coef;
        logic                  last;
    } bwn_entry_t;

endpackage

// File: rtl/bwn_skid_fifo2.sv
// bwn_skid_fifo2
// Two-entry valid/ready buffer. The occupancy output is the issue credit for
// the producer: the producer only pushes while count_o < 2, so there is no
// in_ready and no overflow path here.
// Ports:
//   clk_i, rst_ni     : clock, asynchronous active-low reset (flushes entries)
//   push_i, push_data_i : write one entry (only legal while count_o < 2)
//   pop_i             : consumer ready; pops the head when valid_o is high
//   pop_data_o        : head entry (reads 0 after reset)
//   valid_o           : buffer not empty
//   count_o           : occupancy 0..2
module bwn_skid_fifo2 #(
    parameter int W = 81
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_pop;

    assign do_pop = pop_i && (count_q != 2'd0);

    // Simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        count_d = count_q;
        case ({push_i, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign valid_o    = (count_q != 2'd0);
    assign count_o    = count_q;

endmodule

// File: rtl/bwn_coef_fetch_ctrl.sv
// bwn_coef_fetch_ctrl
// Streams a burst of coefficient words from the combinational coefficient ROM
// to the XNOR/popcount datapath. The ROM address is registered; the word read
// at that address is captured into a 2-entry output FIFO at the end of the
// same cycle, so the first word is valid two cycles after command accept.
// Optional build macro: BWN_COEF_REPEAT_EN adds cmd_rep (burst replay count).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  : command handshake (accept when both high)
//   cmd_base, cmd_len    : first address and word count of the burst
//   cmd_rep              : (BWN_COEF_REPEAT_EN only) extra passes over the burst
//   rom_addr, rom_coef   : ROM address out, ROM data in
//   out_valid/out_ready  : data handshake; a word transfers when both are high
//                          and the word/last stay stable while stalled
//   out_coef, out_last   : coefficient word, final-word marker
//   busy                 : FSM not IDLE
//   done, err            : one-cycle completion / out-of-range pulses
//   dbg_state            : current FSM state (bwn_state_e encoding)
module bwn_coef_fetch_ctrl
    import bwn_pkg::*;
#(
    parameter int WIDTH_A = BWN_ADDR_W,
    parameter int WIDTH_D = BWN_COEF_W,
    parameter int DEPTH   = BWN_ROM_DEPTH,
    parameter int WIDTH_L = BWN_LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [WIDTH_A-1:0] cmd_base,
    input  logic [WIDTH_L-1:0] cmd_len,
`ifdef BWN_COEF_REPEAT_EN
    input  logic [3:0]         cmd_rep,
`endif
    output logic [WIDTH_A-1:0] rom_addr,
    input  logic [WIDTH_D-1:0] rom_coef,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH_D-1:0] out_coef,
    output logic               out_last,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         dbg_state
);

    bwn_state_e         state_q, state_d;
    logic [WIDTH_A-1:0] addr_q, addr_d;
    logic [WIDTH_L-1:0] cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef BWN_COEF_REPEAT_EN
    logic [WIDTH_A-1:0] base_q, base_d;
    logic [WIDTH_L-1:0] len_q, len_d;
    logic [3:0]         rep_q, rep_d;
`endif

    logic               push;
    logic               push_last;
    bwn_entry_t         push_entry;
    bwn_entry_t         pop_entry;
    logic [1:0]         fifo_count;
    logic [WIDTH_A:0]   end_addr;
    logic               range_bad;

    // One bit wider than the address so base+len cannot wrap past the check.
    assign end_addr  = {1'b0, cmd_base} + (WIDTH_A+1)'(cmd_len);
    assign range_bad = end_addr > (WIDTH_A+1)'(DEPTH);

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        push      = 1'b0;
        push_last = 1'b0;
`ifdef BWN_COEF_REPEAT_EN
        base_d    = base_q;
        len_d     = len_q;
        rep_d     = rep_q;
`endif
        case (state_q)
            IDLE: begin
                // cmd_ready is high in IDLE, so cmd_valid alone means accept.
                if (cmd_valid) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmd_base;
                        cnt_d   = cmd_len;
                        state_d = ISSUE;
`ifdef BWN_COEF_REPEAT_EN
                        base_d  = cmd_base;
                        len_d   = cmd_len;
                        rep_d   = cmd_rep;
`endif
                    end
                end
            end
            ISSUE: begin
                // Capture the word at rom_addr only when the FIFO has a free slot.
                if (fifo_count < 2'd2) begin
                    push = 1'b1;
                    if (cnt_q == WIDTH_L'(1)) begin
`ifdef BWN_COEF_REPEAT_EN
                        if (rep_q != 4'd0) begin
                            rep_d  = rep_q - 4'd1;
                            addr_d = base_q;
                            cnt_d  = len_q;
                        end else begin
                            push_last = 1'b1;
                            state_d   = DRAIN;
                        end
`else
                        push_last = 1'b1;
                        state_d   = DRAIN;
`endif
                    end else begin
                        // Address holds on the final word so it never passes DEPTH-1.
                        addr_d = addr_q + WIDTH_A'(1);
                        cnt_d  = cnt_q - WIDTH_L'(1);
                    end
                end
            end
            DRAIN: begin
                // The last-marked word is the youngest entry, so its handshake empties the FIFO.
                if (out_valid && out_ready && out_last) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef BWN_COEF_REPEAT_EN
            base_q  <= '0;
            len_q   <= '0;
            rep_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef BWN_COEF_REPEAT_EN
            base_q  <= base_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
`endif
        end
    end

    assign push_entry.coef = rom_coef;
    assign push_entry.last = push_last;

    bwn_skid_fifo2 #(
        .W($bits(bwn_entry_t))
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (out_ready),
        .pop_data_o  (pop_entry),
        .valid_o     (out_valid),
        .count_o     (fifo_count)
    );

    assign out_coef  = pop_entry.coef;
    assign out_last  = pop_entry.last;
    assign rom_addr  = addr_q;
    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule
